instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter WIDTH_INSTR, default 16, instruction word width.
REQ-002 SHALL have parameter WIDTH_JDATA, default 24, program-counter and jump-target width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, prefetch buffer entries (power of 2, at least 2).
REQ-004 SHALL have parameter BOOT_ADDR, default 0, first fetch address after start.
REQ-005 SHALL have ports clk  input  1  clock; rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports start  input  1  begin fetching at BOOT_ADDR; halt  input  1  stop fetching.
REQ-007 SHALL have ports imem_en  output  1  read strobe; imem_addr  output  WIDTH_JDATA  read address; imem_rdata  input  WIDTH_INSTR  read data, valid exactly 1 cycle after imem_en.
REQ-008 SHALL have ports instr  output  WIDTH_INSTR  head instruction; valid  output  1  instr valid; next_instr  input  1  consumer pop.
REQ-009 SHALL have ports jump  input  1  redirect; jdata  input  WIDTH_JDATA  target; exe_flush  output  1  discard pulse to execute stage.
REQ-010 SHALL have ports busy  output  1  state not IDLE; pc  output  WIDTH_JDATA  next fetch address.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FLUSH.
REQ-012 SHALL go IDLE->RUN on start, loading pc=BOOT_ADDR.
REQ-013 SHALL go RUN->FLUSH on jump, loading pc=jdata in the same edge.
REQ-014 SHALL go FLUSH->RUN unconditionally after exactly 1 cycle.
REQ-015 SHALL go RUN->IDLE on halt when jump=0; jump has priority over halt.
REQ-016 SHALL ignore start outside IDLE and ignore jump outside RUN.
REQ-017 SHALL assert imem_en with imem_addr=pc, and increment pc by 1 (modulo 2^WIDTH_JDATA, wrap silently), only in RUN with jump=0, halt=0 and (fifo_count + inflight) < FIFO_DEPTH.
REQ-018 SHALL write imem_rdata into the FIFO on the cycle after imem_en unless that response is discarded.
REQ-019 SHALL discard a response whose request preceded a jump, and SHALL clear the FIFO in the jump cycle.
REQ-020 SHALL drive exe_flush=1 for exactly the FLUSH cycle and valid=0 during FLUSH and IDLE.
REQ-021 SHALL drive valid=1 iff state is RUN and the FIFO is non-empty, with instr=FIFO head (first-word fall-through).
REQ-022 SHALL pop on valid && next_instr; next_instr while valid=0 SHALL have no effect.
REQ-023 SHALL support simultaneous push and pop on a full or empty FIFO, leaving count unchanged.
REQ-024 SHALL give jump priority over a pop in the same cycle: the FIFO is cleared.
REQ-025 SHALL sustain 1 instruction per cycle in steady state; latency from start to first valid SHALL be 2 cycles.
REQ-026 SHALL, on halt, stop new requests, still accept an in-flight response, and retain FIFO contents for inspection while valid=0; a later start SHALL clear the FIFO.

Reset
REQ-027 SHALL, on rst_n=0 asynchronously, set state=IDLE, pc=BOOT_ADDR, FIFO empty, inflight=0, imem_en=0, valid=0, exe_flush=0, busy=0, and drive imem_addr=BOOT_ADDR.
REQ-028 SHALL, on reset mid-operation, discard any in-flight response arriving after reset deassertion.

Configuration
REQ-029 SHALL provide macro INSTR_FETCH_STATS_EN.
REQ-030 SHALL, with INSTR_FETCH_STATS_EN defined, add outputs fetch_cnt (32) counting pops and flush_cnt (16) counting FLUSH entries, both saturating and both reset to 0.
REQ-031 SHALL, without INSTR_FETCH_STATS_EN, omit those ports and counters entirely, with otherwise identical behaviour.

Verification
REQ-032 SHALL cover: reset, start, next_instr held 1, imem returning addr -> valid at cycle 2, instr sequence 0,1,2,3 at one per cycle.
REQ-033 SHALL cover: next_instr=0 for 10 cycles after start -> FIFO fills to 4, imem_en deasserts, no overflow; release -> order preserved.
REQ-034 SHALL cover: jump with jdata=0x100 while a request is in flight -> exe_flush for 1 cycle, stale word dropped, next valid instr from 0x100.
REQ-035 SHALL cover: jump and halt in the same cycle -> FLUSH taken, then RUN.
REQ-036 SHALL cover: pc=0xFFFFFF fetch -> next imem_addr=0x000000.
REQ-037 SHALL cover: rst_n pulsed low mid-run -> all outputs at reset values immediately; with STATS_EN defined, counters read 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Prefetching instruction fetch unit with a first-word fall-through buffer.
// Define INSTR_FETCH_STATS_EN to add saturating fetch/flush counters.
module instr_fetch #(
   parameter int                     WIDTH_INSTR = 16,
   parameter int                     WIDTH_JDATA = 24,
   parameter int                     FIFO_DEPTH  = 4,
   parameter logic [WIDTH_JDATA-1:0] BOOT_ADDR   = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   halt,
   output logic                   imem_en,
   output logic [WIDTH_JDATA-1:0] imem_addr,
   input  logic [WIDTH_INSTR-1:0] imem_rdata,
   output logic [WIDTH_INSTR-1:0] instr,
   output logic                   valid,
   input  logic                   next_instr,
   input  logic                   jump,
   input  logic [WIDTH_JDATA-1:0] jdata,
   output logic                   exe_flush,
   output logic                   busy,
   output logic [WIDTH_JDATA-1:0] pc
`ifdef INSTR_FETCH_STATS_EN
   ,
   output logic [31:0]            fetch_cnt,
   output logic [15:0]            flush_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH_JDATA-1:0] pc_q, pc_d;
   logic                   inflight_q;
   logic [AW-1:0]          rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH_INSTR-1:0] mem_q [FIFO_DEPTH];
   logic                   req, clr, push, pop;
   logic [CW:0]            occ;

   // Outstanding requests count against capacity so a response always has a slot.
   assign occ = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req     = 1'b0;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = BOOT_ADDR;
               clr     = 1'b1;
            end
         end
         RUN: begin
            if (jump) begin
               state_d = FLUSH;
               pc_d    = jdata;
               clr     = 1'b1;
            end else if (halt) begin
               state_d = IDLE;
            end else if (occ < DEPTH_C) begin
               req  = 1'b1;
               pc_d = pc_q + WIDTH_JDATA'(1);
            end
         end
         FLUSH: state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   assign valid = (state_q == RUN) && (cnt_q != '0);
   assign push  = inflight_q && !clr;
   assign pop   = valid && next_instr && !clr;

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= BOOT_ADDR;
         inflight_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= req;
         if (clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= imem_rdata;
   end

   assign imem_en   = req;
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign instr     = mem_q[rd_ptr_q];
   assign busy      = (state_q != IDLE);
   assign exe_flush = (state_q == FLUSH);

`ifdef INSTR_FETCH_STATS_EN
   logic [31:0] fetch_cnt_q;
   logic [15:0] flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (pop && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (state_d == FLUSH && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instr_fetch;
   localparam int WI = 16;
   localparam int WJ = 24;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst_n, start, halt, imem_en, valid, next_instr, jump;
   logic          exe_flush, busy;
   logic [WJ-1:0] imem_addr, jdata, pc;
   logic [WI-1:0] imem_rdata, instr;
`ifdef INSTR_FETCH_STATS_EN
   logic [31:0]   fetch_cnt;
   logic [15:0]   flush_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   instr_fetch #(.WIDTH_INSTR(WI), .WIDTH_JDATA(WJ), .FIFO_DEPTH(D), .BOOT_ADDR('0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr(instr), .valid(valid), .next_instr(next_instr),
      .jump(jump), .jdata(jdata), .exe_flush(exe_flush),
      .busy(busy), .pc(pc)
`ifdef INSTR_FETCH_STATS_EN
      , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory returns the low address bits one cycle after the strobe; junk otherwise.
   always @(posedge clk) imem_rdata <= imem_en ? imem_addr[WI-1:0] : WI'($urandom);

   task automatic apply_reset;
      rst_n = 1'b0; start = 1'b0; halt = 1'b0;
      next_instr = 1'b0; jump = 1'b0; jdata = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      apply_reset;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({imem_en, valid, exe_flush, busy} !== 4'b0) begin
         n_bad++; $display("FAIL reset_flags got %b exp 0000", {imem_en, valid, exe_flush, busy});
      end
      n_cmp++;
      if (imem_addr !== 24'h0 || pc !== 24'h0) begin
         n_bad++; $display("FAIL reset_addr got %h/%h exp 0", imem_addr, pc);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_stream;
      apply_reset;
      @(negedge clk); start = 1'b1; next_instr = 1'b1;
      @(negedge clk); start = 1'b0; #1;
      n_cmp++;
      if (imem_en !== 1'b1 || imem_addr !== 24'h0 || valid !== 1'b0) begin
         n_bad++; $display("FAIL stream_req got en=%b a=%h v=%b exp 1/0/0", imem_en, imem_addr, valid);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (valid !== 1'b0) begin
         n_bad++; $display("FAIL stream_lat1 got valid=%b exp 0", valid);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if ({valid, instr} !== {1'b1, 16'(i)}) begin
            n_bad++; $display("FAIL stream_seq%0d got v=%b i=%h exp 1/%h", i, valid, instr, i);
         end
      end
   endtask

   task automatic test_fill;
      int en_cnt;
      en_cnt = 0;
      apply_reset;
      @(negedge clk); start = 1'b1; next_instr = 1'b0;
      @(negedge clk); start = 1'b0;
      repeat (10) begin
         #1; if (imem_en) en_cnt++;
         @(negedge clk);
      end
      #1;
      n_cmp++;
      if (en_cnt !== 4 || imem_en !== 1'b0) begin
         n_bad++; $display("FAIL fill_reqs got %0d en=%b exp 4/0", en_cnt, imem_en);
      end
      n_cmp++;
      if ({valid, instr} !== {1'b1, 16'h0}) begin
         n_bad++; $display("FAIL fill_head got v=%b i=%h exp 1/0000", valid, instr);
      end
      next_instr = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if ({valid, instr} !== {1'b1, 16'(i)}) begin
            n_bad++; $display("FAIL fill_drain%0d got v=%b i=%h exp 1/%h", i, valid, instr, i);
         end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_jump_and_halt;
      apply_reset;
      @(negedge clk); start = 1'b1; next_instr = 1'b0;
      @(negedge clk); start = 1'b0; #1;
      @(negedge clk); jump = 1'b1; jdata = 24'h100; #1;
      n_cmp++;
      if (imem_en !== 1'b0) begin
         n_bad++; $display("FAIL jump_noreq got en=%b exp 0", imem_en);
      end
      @(negedge clk); jump = 1'b0; #1;
      n_cmp++;
      if ({exe_flush, valid, imem_en} !== 3'b100 || pc !== 24'h100) begin
         n_bad++; $display("FAIL jump_flush got f/v/e=%b pc=%h exp 100/100", {exe_flush, valid, imem_en}, pc);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (exe_flush !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 24'h100) begin
         n_bad++; $display("FAIL jump_refetch got f=%b e=%b a=%h exp 0/1/100", exe_flush, imem_en, imem_addr);
      end
      @(negedge clk);
      @(negedge clk); #1;
      n_cmp++;
      if ({valid, instr} !== {1'b1, 16'h0100}) begin
         n_bad++; $display("FAIL jump_target got v=%b i=%h exp 1/0100", valid, instr);
      end
      @(negedge clk); jump = 1'b1; halt = 1'b1; jdata = 24'h200;
      @(negedge clk); jump = 1'b0; halt = 1'b0; #1;
      n_cmp++;
      if ({exe_flush, busy} !== 2'b11) begin
         n_bad++; $display("FAIL jh_flush got f/b=%b exp 11", {exe_flush, busy});
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({busy, exe_flush, imem_en} !== 3'b101 || imem_addr !== 24'h200) begin
         n_bad++; $display("FAIL jh_run got b/f/e=%b a=%h exp 101/200", {busy, exe_flush, imem_en}, imem_addr);
      end
   endtask

   task automatic test_wrap;
      apply_reset;
      @(negedge clk); start = 1'b1; next_instr = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); jump = 1'b1; jdata = 24'hFFFFFF;
      @(negedge clk); jump = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if (imem_en !== 1'b1 || imem_addr !== 24'hFFFFFF) begin
         n_bad++; $display("FAIL wrap_top got e=%b a=%h exp 1/ffffff", imem_en, imem_addr);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (imem_en !== 1'b1 || imem_addr !== 24'h000000) begin
         n_bad++; $display("FAIL wrap_zero got e=%b a=%h exp 1/000000", imem_en, imem_addr);
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({valid, instr} !== {1'b1, 16'hFFFF}) begin
         n_bad++; $display("FAIL wrap_i0 got v=%b i=%h exp 1/ffff", valid, instr);
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({valid, instr} !== {1'b1, 16'h0000}) begin
         n_bad++; $display("FAIL wrap_i1 got v=%b i=%h exp 1/0000", valid, instr);
      end
   endtask

   task automatic test_halt;
      apply_reset;
      @(negedge clk); start = 1'b1; next_instr = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk); halt = 1'b1; #1;
      n_cmp++;
      if (imem_en !== 1'b0) begin
         n_bad++; $display("FAIL halt_noreq got en=%b exp 0", imem_en);
      end
      @(negedge clk); halt = 1'b0; next_instr = 1'b1; #1;
      n_cmp++;
      if ({busy, valid, imem_en} !== 3'b000 || instr !== 16'h0) begin
         n_bad++; $display("FAIL halt_idle got b/v/e=%b i=%h exp 000/0000", {busy, valid, imem_en}, instr);
      end
      @(negedge clk); next_instr = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; #1;
      n_cmp++;
      if (valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 24'h0) begin
         n_bad++; $display("FAIL halt_restart got v=%b e=%b a=%h exp 0/1/0", valid, imem_en, imem_addr);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (valid !== 1'b0) begin
         n_bad++; $display("FAIL halt_cleared got v=%b exp 0", valid);
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({valid, instr} !== {1'b1, 16'h0}) begin
         n_bad++; $display("FAIL halt_first got v=%b i=%h exp 1/0000", valid, instr);
      end
   endtask

   task automatic test_reset_mid;
      apply_reset;
      @(negedge clk); start = 1'b1; next_instr = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      n_cmp++;
      if ({imem_en, valid, exe_flush, busy} !== 4'b0 || imem_addr !== 24'h0 || pc !== 24'h0) begin
         n_bad++; $display("FAIL rstmid_out got %b a=%h pc=%h exp 0000/0/0", {imem_en, valid, exe_flush, busy}, imem_addr, pc);
      end
`ifdef INSTR_FETCH_STATS_EN
      n_cmp++;
      if (fetch_cnt !== 32'h0 || flush_cnt !== 16'h0) begin
         n_bad++; $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", fetch_cnt, flush_cnt);
      end
`endif
      #1 rst_n = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; #1;
      n_cmp++;
      if (valid !== 1'b0 || imem_addr !== 24'h0) begin
         n_bad++; $display("FAIL rstmid_restart got v=%b a=%h exp 0/0", valid, imem_addr);
      end
      @(negedge clk);
      @(negedge clk); #1;
      n_cmp++;
      if ({valid, instr} !== {1'b1, 16'h0}) begin
         n_bad++; $display("FAIL rstmid_first got v=%b i=%h exp 1/0000", valid, instr);
      end
   endtask

   task automatic test_random;
      logic [WI-1:0] q[$];
      logic [WJ-1:0] fa;
      bit            flushing;
      int            pending, avail, npop, nflush;
      logic          exp_en, exp_valid;
      apply_reset;
      @(negedge clk); start = 1'b1;
      fa = '0; flushing = 1'b0; pending = 0; npop = 0; nflush = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         next_instr = ($urandom % 10) < 6;
         jump       = ($urandom % 16) == 0;
         jdata      = WJ'($urandom);
         start      = 1'($urandom);
         #1;
         exp_en    = !flushing && !jump && (q.size() < D);
         avail     = q.size() - pending;
         exp_valid = !flushing && (avail > 0);
         n_cmp++;
         if (imem_en !== exp_en || (exp_en && imem_addr !== fa)) begin
            n_bad++; $display("FAIL rnd_req c%0d got e=%b a=%h exp %b/%h", c, imem_en, imem_addr, exp_en, fa);
         end
         n_cmp++;
         if (valid !== exp_valid || (exp_valid && instr !== q[0])) begin
            n_bad++; $display("FAIL rnd_out c%0d got v=%b i=%h exp %b", c, valid, instr, exp_valid);
         end
         n_cmp++;
         if (exe_flush !== flushing || busy !== 1'b1) begin
            n_bad++; $display("FAIL rnd_state c%0d got f=%b b=%b exp %b/1", c, exe_flush, busy, flushing);
         end
         if (flushing) begin
            flushing = 1'b0;
         end else if (jump) begin
            q.delete(); pending = 0; fa = jdata; flushing = 1'b1; nflush++;
         end else begin
            if (exp_valid && next_instr) begin
               void'(q.pop_front()); npop++;
            end
            if (exp_en) begin
               q.push_back(fa[WI-1:0]); fa = fa + 1'b1;
            end
            pending = exp_en ? 1 : 0;
         end
      end
      start = 1'b0; jump = 1'b0; next_instr = 1'b0;
`ifdef INSTR_FETCH_STATS_EN
      @(negedge clk); #1;
      n_cmp++;
      if (fetch_cnt !== 32'(npop) || flush_cnt !== 16'(nflush)) begin
         n_bad++; $display("FAIL rnd_stats got %0d/%0d exp %0d/%0d", fetch_cnt, flush_cnt, npop, nflush);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_stream;
      test_fill;
      test_jump_and_halt;
      test_wrap;
      test_halt;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
